// File: rtl/sram_ctrl_pkg.sv
// Shared types, defaults and elaboration helpers for the 1RW SRAM request controller.
package sram_ctrl_pkg;

  localparam int DEF_BITS       = 32;
  localparam int DEF_WORD_DEPTH = 16384;
  localparam int DEF_ADDR_WIDTH = 14;

  // One buffered read response: error flag plus returned data word.
  typedef struct packed {
    logic                err;
    logic [DEF_BITS-1:0] rdata;
  } rsp_entry_t;

  // The response FIFO needs at least two slots so a push and a pop can overlap.
  function automatic bit rsp_depth_ok(input int depth);
    return depth >= 2;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read responses in issue order.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 3,
  parameter type entry_t = rsp_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           mem_q [DEPTH];
  logic             full;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; flags pushes that arrive while full.
  // NOTE: storage is deliberately not reset -- empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    if (rst_n && push_i) begin
      assert (!full) else $error("sram_rsp_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Initiator-side controller for a 1RW SRAM macro: credit-gated requests, in-order read responses.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  if (!rsp_depth_ok(RSP_DEPTH)) begin : g_depth_check
    $error("sram_1rw_req_ctrl: RSP_DEPTH must be at least 2");
  end

  typedef struct packed {
    logic            err;
    logic [BITS-1:0] rdata;
  } entry_t;

  logic             rst_done_q;
  logic             rd_inflight_q, rd_inflight_d;
  logic             rd_err_q, rd_err_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;
  logic             fifo_empty;
  logic             fire, in_range, pop;
  entry_t           push_entry, head;

  // Credit check uses registered state only, so rsp_ready never reaches req_ready.
  assign credits_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(rd_inflight_q);
  assign req_ready    = rst_done_q && (credits_used < (CNT_W + 1)'(RSP_DEPTH));
  assign fire         = req_valid && req_ready;
  assign in_range     = 32'(req_addr) < 32'(WORD_DEPTH);

  assign rd_inflight_d = fire && !req_we;
  assign rd_err_d      = fire && !req_we && !in_range;

  // Out-of-range reads never touch the macro, so their data is forced to zero.
  assign push_entry.err   = rd_err_q;
  assign push_entry.rdata = rd_err_q ? '0 : sram_rd;

  // Macro pins follow the fire cycle; everything is zeroed when the macro is idle.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    sram_ce    = fire && in_range;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wd    = '0;
    sram_wmask = '0;
    if (sram_ce) begin
      sram_we    = req_we;
      sram_addr  = req_addr;
      sram_wd    = req_wdata;
      sram_wmask = req_wmask;
    end
  end

  // Reset-done flag and the one-deep read-in-flight stage that feeds the FIFO.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
      rd_err_q      <= 1'b0;
    end else begin
      rst_done_q    <= 1'b1;
      rd_inflight_q <= rd_inflight_d;
      rd_err_q      <= rd_err_d;
    end
  end

  assign pop = rsp_valid && rsp_ready;

  sram_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = head.rdata;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference.
module tb_sram_1rw_req_ctrl;

  localparam int BITS        = 32;
  localparam int ADDR_WIDTH  = 14;
  localparam int WORD_DEPTH  = 10000;
  localparam int RSP_DEPTH   = 3;
  localparam int MACRO_WORDS = 16384;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_we = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [BITS-1:0]       req_wdata = '0;
  logic [BITS-1:0]       req_wmask = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [BITS-1:0]       rsp_rdata;
  logic                  rsp_err;
  logic                  sram_ce;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [BITS-1:0]       sram_wd;
  logic [BITS-1:0]       sram_wmask;
  logic [BITS-1:0]       sram_rd = '0;

  always #5 clk = ~clk;

  sram_1rw_req_ctrl #(
    .BITS       (BITS),
    .WORD_DEPTH (WORD_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_wmask (sram_wmask),
    .sram_rd    (sram_rd)
  );

  // Macro model: masked write, read data appears after the access edge, ignores reset.
  logic [BITS-1:0] macro_mem [MACRO_WORDS];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
      else         sram_rd <= macro_mem[sram_addr];
    end
  end

  // Reference: expected memory image plus an ordered list of pending responses.
  typedef struct {
    logic            err;
    logic [BITS-1:0] data;
    int              avail;
  } exp_t;

  exp_t            exp_q[$];
  logic [BITS-1:0] shadow [MACRO_WORDS];
  bit              rst_done_m = 1'b0;
  bit              last_fire = 1'b0;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  int              ce_cnt = 0;
  int              fire_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: called right after a negedge with inputs already driven.
  task automatic tick();
    bit              exp_ready, fire, in_rng, exp_ce, head_ok;
    logic [BITS-1:0] old;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      rst_done_m = 1'b0;
    end
    exp_ready = rst_done_m && (exp_q.size() < RSP_DEPTH);
    check("req_ready", req_ready, exp_ready);
    fire   = req_valid && exp_ready;
    in_rng = int'(req_addr) < WORD_DEPTH;
    exp_ce = fire && in_rng;
    check("sram_ce", sram_ce, exp_ce);
    check("sram_we", sram_we, exp_ce && req_we);
    check("sram_addr", sram_addr, exp_ce ? req_addr : '0);
    check("sram_wd", sram_wd, exp_ce ? req_wdata : '0);
    check("sram_wmask", sram_wmask, exp_ce ? req_wmask : '0);
    if (sram_ce) ce_cnt++;
    head_ok = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check("rsp_valid", rsp_valid, head_ok);
    if (head_ok) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].data);
      check("rsp_err", rsp_err, exp_q[0].err);
      if (rsp_ready) void'(exp_q.pop_front());
    end
    if (fire) begin
      fire_cnt++;
      if (req_we) begin
        if (in_rng) begin
          old = shadow[req_addr];
          shadow[req_addr] = (old & ~req_wmask) | (req_wdata & req_wmask);
        end
      end else begin
        exp_q.push_back('{err: !in_rng, data: in_rng ? shadow[req_addr] : '0, avail: cyc + 2});
      end
    end
    last_fire  = fire;
    rst_done_m = rst_n;
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input bit we, input logic [ADDR_WIDTH-1:0] a,
                       input logic [BITS-1:0] d, input logic [BITS-1:0] m);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 20);
    check("issue_accept", last_fire, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int c0, ce0, accepted, n;
    for (int i = 0; i < MACRO_WORDS; i++) begin
      macro_mem[i] = '0;
      shadow[i]    = '0;
    end
    @(negedge clk);

    // Reset state, then one cycle of req_ready=0 after release.
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("rst_ready_low", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    #1;
    check("rst_ready_high", req_ready, 1'b1);

    // Full write then read-after-write with exact two-cycle latency.
    rsp_ready = 1'b1;
    issue(1'b1, 14'h0010, 32'hDEADBEEF, 32'hFFFFFFFF);
    issue(1'b0, 14'h0010, '0, '0);
    tick();
    #1;
    check("lat2_valid", rsp_valid, 1'b1);
    check("lat2_rdata", rsp_rdata, 32'hDEADBEEF);
    check("lat2_err", rsp_err, 1'b0);
    drain();

    // Masked overwrite keeps the upper half.
    issue(1'b1, 14'h0010, 32'h00000000, 32'h0000FFFF);
    issue(1'b0, 14'h0010, '0, '0);
    tick();
    #1;
    check("mask_rdata", rsp_rdata, 32'hDEAD0000);
    drain();

    // Fill addresses 0..7, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) issue(1'b1, 14'(i), $urandom, 32'hFFFFFFFF);
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue(1'b0, 14'(i), '0, '0);
    check("b2b_cycles", cyc - c0, 8);
    drain();

    // Backpressure: only three reads fit while the consumer stalls.
    rsp_ready = 1'b0;
    ce0       = ce_cnt;
    accepted  = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 14'(accepted);
      tick();
      if (last_fire) accepted++;
    end
    check("bp_accepted", accepted, 3);
    check("bp_ce_pulses", ce_cnt - ce0, 3);
    #1;
    check("bp_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    n = 0;
    while ((accepted < 5 || exp_q.size() > 0) && n < 40) begin
      req_valid = (accepted < 5);
      req_addr  = 14'(accepted);
      tick();
      if (last_fire) accepted++;
      n++;
    end
    req_valid = 1'b0;
    check("bp_resume", accepted, 5);
    check("bp_drained", exp_q.size(), 0);

    // Out-of-range read returns an error; out-of-range write vanishes.
    ce0 = ce_cnt;
    issue(1'b0, 14'd12000, '0, '0);
    tick();
    #1;
    check("oor_rd_err", rsp_err, 1'b1);
    check("oor_rd_data", rsp_rdata, '0);
    drain();
    issue(1'b1, 14'd12000, 32'h12345678, 32'hFFFFFFFF);
    repeat (3) tick();
    check("oor_no_ce", ce_cnt - ce0, 0);
    check("oor_wr_no_rsp", rsp_valid, 1'b0);

    // Reset with one response buffered and one read in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 14'd1, '0, '0);
    issue(1'b0, 14'd2, '0, '0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("midrst_ready0", req_ready, 1'b0);
    tick();
    #1;
    check("midrst_ready1", req_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      if (!req_valid || last_fire) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(10000, 16383))
                                                 : 14'($urandom_range(0, 63));
        req_wdata = $urandom;
        req_wmask = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw_req_ctrl.md
Name: sram_1rw_req_ctrl

Overview:
- Initiator-side controller for the single-port 32x16384 1RW SRAM macro (sram_32x16384_1rw).
- Accepts valid/ready read/write requests and drives the macro's ce/we/addr/wd/mask pins.
- Captures read data one cycle after access and returns it in order on a valid/ready response port, buffered in a small FIFO.
- Credit-based issue, so the macro is never read without a guaranteed response slot.

Parameters:
- BITS, 32, data/mask width.
- WORD_DEPTH, 16384, number of words; addresses >= WORD_DEPTH are out of range.
- ADDR_WIDTH, 14, address width.
- RSP_DEPTH, 3, response FIFO entries; minimum 2; 3 is required for 1 read/cycle sustained throughput.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready (fire).
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  BITS  write data.
- req_wmask  in  BITS  per-bit write enable, 1=write bit.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  consumer ready.
- rsp_rdata  out  BITS  read data.
- rsp_err  out  1  1=out-of-range read, rdata forced 0.
- sram_ce  out  1  macro chip enable.
- sram_we  out  1  macro write enable.
- sram_addr  out  ADDR_WIDTH  macro address.
- sram_wd  out  BITS  macro write data.
- sram_wmask  out  BITS  macro write mask.
- sram_rd  in  BITS  macro read data, valid the cycle after a read access.

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset state: rsp_valid=0, FIFO empty, rd_inflight=0, rst_done=0.
- rst_done rises on the first clk edge after rst_n deasserts. req_ready=0 and sram_ce=0 while rst_done=0.
- Credit rule: req_ready = rst_done && (fifo_count + rd_inflight) < RSP_DEPTH. Computed from registers only; there is no combinational path from rsp_ready to req_ready. A pop in the current cycle frees credit next cycle.
- Writes consume no response slot but are gated by the same req_ready.
- Macro drive is combinational from the fire cycle:
  - sram_ce = fire && (req_addr < WORD_DEPTH).
  - sram_we = sram_ce && req_we.
  - sram_addr/sram_wd/sram_wmask = request fields when sram_ce, else 0.
- Writes: no response. Out-of-range writes are dropped silently (sram_ce stays 0).
- Reads: rd_inflight set on a read fire; the entry is pushed into the FIFO on the next edge.
  - In-range read pushes {err=0, rdata=sram_rd}.
  - Out-of-range read does not access the macro and pushes {err=1, rdata=0}.
  - Ordering is preserved.
- Read latency: request fire in cycle N -> rsp_valid no earlier than N+2, when the FIFO is empty and rsp_ready is held.
- Throughput: sustained 1 read/cycle with RSP_DEPTH=3 and rsp_ready=1.
- Response handshake: rsp_valid/rsp_rdata/rsp_err are held stable until rsp_ready. Push and pop in the same cycle are both legal when not full.
- Write at cycle N followed by a read of the same address at N+1 returns the new masked data (macro semantics).
- Mask: bit i is written only when sram_wmask[i]=1; unmasked bits keep their old value.
- FIFO overflow is impossible by the credit rule; a push into a full FIFO is an assertion failure.
- Reset mid-operation: in-flight reads and FIFO contents are discarded and no response is produced. Macro contents are not touched.

Decomposition:
- Package sram_ctrl_pkg:
  - Response entry typedef {err, rdata[BITS-1:0]}.
  - Defaults: BITS=32, WORD_DEPTH=16384, ADDR_WIDTH=14.
  - Assertion helper for RSP_DEPTH>=2.
- One sub-module: sram_rsp_fifo, a synchronous FIFO of entry type, depth RSP_DEPTH, with count output. Async active-low reset clears pointers only.

Test Plan:
- Write addr 0x0010 data 0xDEADBEEF mask 0xFFFFFFFF, then read 0x0010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after read fire.
- Masked overwrite: write 0x0010 data 0x00000000 mask 0x0000FFFF, then read -> 0xDEAD0000.
- Back-to-back: 8 reads of addrs 0..7 with rsp_ready=1 -> req_ready never drops after the first fire, and 8 responses arrive in address order on consecutive cycles.
- Backpressure: rsp_ready=0, issue 5 reads -> exactly 3 accepted (req_ready=0 afterwards) and sram_ce pulses exactly 3 times. Release rsp_ready -> 3 responses in order, then remaining issues resume.
- Out-of-range with WORD_DEPTH=10000: read addr 12000 -> sram_ce stays 0, response rsp_err=1, rdata=0. Write addr 12000 -> no sram_ce, no response.
- Assert rst_n low with 2 reads in flight/buffered -> rsp_valid=0 immediately. After release, req_ready=0 for one cycle then 1, and no stale responses appear.
